// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED control.
// Redirects take priority over stalls; a HALT_INSTR word parks fetch until the next redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_if,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pp4_q, pp4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pp4_d   = pp4_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      // low target bits are dropped; the error flag records that it happened
      pc_d    = {redirect_target[31:2], 2'b00};
      instr_d = 32'h0;
      pp4_d   = 32'h0;
      valid_d = 1'b0;
      state_d = RUN;
      mis_d   = mis_q | (redirect_target[1:0] != 2'b00);
    end else if (stall_if) begin
      state_d = state_q;
    end else if (state_q == HALTED) begin
      instr_d = 32'h0;
      pp4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (imem_data == HALT_INSTR) begin
      instr_d = 32'h0;
      pp4_d   = 32'h0;
      valid_d = 1'b0;
      state_d = HALTED;
    end else begin
      instr_d = imem_data;
      pp4_d   = pc_plus4;
      valid_d = 1'b1;
      pc_d    = pc_plus4;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pp4_q   <= 32'h0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp4_q   <= pp4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign pc_if          = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pp4_q;
  assign if_id_valid    = valid_q;
  assign halted         = (state_q == HALTED);
  assign misalign_err   = mis_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed program sequence followed by random
// stall/redirect/reset traffic, checked against a rule-level model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        halted;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_if = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr, imem_data, pc_if, if_id_instr, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, halted, misalign_err;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr[7:2]];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_if(stall_if),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .pc_if(pc_if),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .halted(halted), .misalign_err(misalign_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  // reference model state
  logic [31:0] m_pc = 0, m_instr = 0, m_pp4 = 0, m_cnt = 0;
  logic        m_valid = 0, m_halted = 0, m_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bubble();
    m_instr = 0; m_pp4 = 0; m_valid = 0;
  endtask

  task automatic model_step(input logic rst, input logic st, input logic rv, input logic [31:0] tgt);
    logic [31:0] w;
    if (!rst) begin
      m_pc = 0; bubble(); m_halted = 0; m_mis = 0; m_cnt = 0;
    end else if (rv) begin
      if (tgt[1:0] != 0) m_mis = 1;
      m_pc = tgt & 32'hFFFF_FFFC;
      bubble();
      m_halted = 0;
    end else if (st) begin
      // everything frozen
    end else if (m_halted) begin
      bubble();
    end else begin
      w = mem[m_pc[7:2]];
      if (w == HALT) begin
        bubble();
        m_halted = 1;
      end else begin
        m_instr = w; m_pp4 = m_pc + 4; m_valid = 1;
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic rv, input logic [31:0] tgt);
    exp_t e;
    rst_n = rst; stall_if = st; redirect_valid = rv; redirect_target = tgt;
    model_step(rst, st, rv, tgt);
    e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid;
    e.halted = m_halted; e.mis = m_mis; e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // monitor: one response per clock edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc_if", pc_if, e.pc);
      chk("imem_addr", imem_addr, e.pc);
      chk("if_id_instr", if_id_instr, e.instr);
      chk("if_id_pc_plus4", if_id_pc_plus4, e.pp4);
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
      chk("halted", {31'b0, halted}, {31'b0, e.halted});
      chk("misalign_err", {31'b0, misalign_err}, {31'b0, e.mis});
      chk("fetch_count", fetch_count, e.cnt);
    end
  end

  initial begin
    int budget;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT) mem[i] = 32'h0;
    end
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020;
    mem[3] = HALT;
    mem[25] = HALT;
    mem[47] = HALT;

    @(negedge clk);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 32'h40);             // reset beats stall and redirect
    cyc(1, 0, 0, 0);                  // fetch 0x0
    cyc(1, 0, 0, 0);                  // fetch 0x4, PC = 0x8
    cyc(1, 1, 0, 0);                  // stall two cycles
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);                  // fetch 0x8
    cyc(1, 0, 0, 0);                  // halt word at 0xC
    cyc(1, 0, 0, 0);                  // stays halted
    cyc(1, 1, 0, 0);                  // stall while halted
    cyc(1, 0, 1, 32'h0);              // redirect clears halt
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 32'h40);             // redirect beats stall
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 32'h43);             // misaligned target
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 32'hFFFF_FFFC);      // PC wrap
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 32'h8);              // back to halt at 0xC
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);                  // reset while halted
    cyc(1, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      logic r, s, v;
      logic [31:0] t;
      r = ($urandom_range(0, 49) != 0);
      s = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 7) == 0);
      t = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 4) == 0) t[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) t = 32'hFFFF_FFF0 | {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      cyc(r, s, v, t);
    end

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
